mem_stage: RTL and testbench

- Memory stage of the 5-stage pipeline. Sits directly downstream of the execute stage and consumes its outputs (ALU result, store data, rd, PC+4, control bits, funct3).
- Contains the EX/MEM pipeline latch and a load/store unit that drives a valid/ready data-memory port.
- Handles byte, halfword and word accesses. A misaligned access is split into two aligned beats.
- Produces the operands for the MEM/WB latch, plus a stall that freezes upstream stages while an access is outstanding.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/lsu_align.sv | 42 ++++
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory stage.
// Access-size and load-result encodings.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

   typedef enum logic {BEAT0, BEAT1} mem_state_t;

   function automatic logic [2:0] acc_bytes(input logic [2:0] f3);
      logic [2:0] n;
      n = 3'd4;
      if (f3[1:0] == F3_B[1:0]) n = 3'd1;
      else if (f3[1:0] == F3_H[1:0]) n = 3'd2;
      return n;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for loads and stores: byte enables, shifted
// store data and extracted/extended load data.
module lsu_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_a,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [63:0] i_rdata,
   output logic [3:0]  o_be0,
   output logic [3:0]  o_be1,
   output logic [63:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_mask;
   logic [31:0] w_sh;
   logic [4:0]  w_bits;

   assign w_bits = {i_a, 3'b000};

   always_comb begin
      w_mask = 8'h0F;
      if (i_funct3[1:0] == F3_B[1:0]) w_mask = 8'h01;
      else if (i_funct3[1:0] == F3_H[1:0]) w_mask = 8'h03;
      {o_be1, o_be0} = w_mask << i_a;
   end

   assign o_wdata = {32'b0, i_wdata} << w_bits;
   assign w_sh    = 32'(i_rdata >> w_bits);

   always_comb begin
      o_rdata = w_sh;
      if (i_funct3[1:0] == F3_B[1:0])
         o_rdata = i_funct3[2] ? {24'b0, w_sh[7:0]}
                               : {{24{w_sh[7]}}, w_sh[7:0]};
      else if (i_funct3[1:0] == F3_H[1:0])
         o_rdata = i_funct3[2] ? {16'b0, w_sh[15:0]}
                               : {{16{w_sh[15]}}, w_sh[15:0]};
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM latch plus a two-beat load/store unit
// that splits misaligned accesses into aligned memory beats.
module mem_stage
   import mem_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               reg_write_e,
   input  logic [1:0]         result_src_e,
   input  logic               mem_write_e,
   input  logic [D_WIDTH-1:0] alu_result_e,
   input  logic [D_WIDTH-1:0] write_data_e,
   input  logic [4:0]         rd_e,
   input  logic [D_WIDTH-1:0] pc_plus_4e,
   input  logic [2:0]         funct3_e,
   output logic               mem_req,
   output logic               mem_we,
   output logic [D_WIDTH-1:0] mem_addr,
   output logic [D_WIDTH-1:0] mem_wdata,
   output logic [3:0]         mem_be,
   input  logic [D_WIDTH-1:0] mem_rdata,
   input  logic               mem_ready,
   output logic               reg_write_m,
   output logic [1:0]         result_src_m,
   output logic [D_WIDTH-1:0] alu_result_m,
   output logic [D_WIDTH-1:0] read_data_m,
   output logic [4:0]         rd_m,
   output logic [D_WIDTH-1:0] pc_plus_4m,
   output logic               stall_m
);

   logic               r_reg_write;
   logic [1:0]         r_result_src;
   logic               r_mem_write;
   logic [D_WIDTH-1:0] r_alu_result;
   logic [D_WIDTH-1:0] r_write_data;
   logic [4:0]         r_rd;
   logic [D_WIDTH-1:0] r_pc_plus_4;
   logic [2:0]         r_funct3;
   logic [D_WIDTH-1:0] r_hold0;
   mem_state_t         r_state;

   mem_state_t         w_state_nxt;
   logic               w_mem_op;
   logic               w_split;
   logic               w_cap0;
   logic               w_done;
   logic [2:0]         w_end;
   logic [D_WIDTH-1:0] w_base;
   logic [3:0]         w_be0;
   logic [3:0]         w_be1;
   logic [63:0]        w_wd64;
   logic [63:0]        w_rd64;
   logic [D_WIDTH-1:0] w_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_write  <= 1'b0;
         r_result_src <= 2'b00;
         r_mem_write  <= 1'b0;
         r_alu_result <= '0;
         r_write_data <= '0;
         r_rd         <= '0;
         r_pc_plus_4  <= '0;
         r_funct3     <= '0;
      end else if (!stall_m) begin
         r_reg_write  <= reg_write_e;
         r_result_src <= result_src_e;
         r_mem_write  <= mem_write_e;
         r_alu_result <= alu_result_e;
         r_write_data <= write_data_e;
         r_rd         <= rd_e;
         r_pc_plus_4  <= pc_plus_4e;
         r_funct3     <= funct3_e;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BEAT0;
         r_hold0 <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cap0) r_hold0 <= mem_rdata;
      end
   end

   assign w_mem_op = r_mem_write | (r_result_src == RESULT_SRC_MEM);
   assign w_end    = {1'b0, r_alu_result[1:0]} + acc_bytes(r_funct3);
   assign w_split  = (w_end > 3'd4);
   assign w_base   = {r_alu_result[D_WIDTH-1:2], 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_cap0      = 1'b0;
      w_done      = 1'b0;
      mem_req     = 1'b0;
      mem_addr    = '0;
      mem_be      = '0;
      mem_wdata   = '0;
      unique case (r_state)
         BEAT0: begin
            mem_req = w_mem_op;
            if (w_mem_op) begin
               mem_addr  = w_base;
               mem_be    = w_be0;
               mem_wdata = w_wd64[31:0];
               if (mem_ready && w_split) begin
                  w_cap0      = 1'b1;
                  w_state_nxt = BEAT1;
               end else if (mem_ready) begin
                  w_done = 1'b1;
               end
            end
         end
         BEAT1: begin
            mem_req   = 1'b1;
            mem_addr  = w_base + 32'd4;
            mem_be    = w_be1;
            mem_wdata = w_wd64[63:32];
            if (mem_ready) begin
               w_done      = 1'b1;
               w_state_nxt = BEAT0;
            end
         end
      endcase
   end

   // Second beat pairs the held first word with the live one.
   assign w_rd64 = (r_state == BEAT1) ? {mem_rdata, r_hold0}
                                      : {32'b0, mem_rdata};

   lsu_align u_align (
      .i_a      (r_alu_result[1:0]),
      .i_funct3 (r_funct3),
      .i_wdata  (r_write_data),
      .i_rdata  (w_rd64),
      .o_be0    (w_be0),
      .o_be1    (w_be1),
      .o_wdata  (w_wd64),
      .o_rdata  (w_rdata)
   );

   assign mem_we       = r_mem_write;
   assign stall_m      = w_mem_op & ~w_done;
   assign reg_write_m  = r_reg_write & ~stall_m;
   assign read_data_m  = w_done ? w_rdata : '0;
   assign result_src_m = r_result_src;
   assign alu_result_m = r_alu_result;
   assign rd_m         = r_rd;
   assign pc_plus_4m   = r_pc_plus_4;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-level reference model checked every
// cycle, plus literal expectations for directed accesses.
module tb_mem_stage;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write_e;
   logic [1:0]  result_src_e;
   logic        mem_write_e;
   logic [31:0] alu_result_e;
   logic [31:0] write_data_e;
   logic [4:0]  rd_e;
   logic [31:0] pc_plus_4e;
   logic [2:0]  funct3_e;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        reg_write_m;
   logic [1:0]  result_src_m;
   logic [31:0] alu_result_m;
   logic [31:0] read_data_m;
   logic [4:0]  rd_m;
   logic [31:0] pc_plus_4m;
   logic        stall_m;

   int checks = 0;
   int errors = 0;
   bit mdl_on = 1'b0;

   always #5 clk = ~clk;

   mem_stage #(.D_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .reg_write_e(reg_write_e), .result_src_e(result_src_e),
      .mem_write_e(mem_write_e), .alu_result_e(alu_result_e),
      .write_data_e(write_data_e), .rd_e(rd_e),
      .pc_plus_4e(pc_plus_4e), .funct3_e(funct3_e),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .reg_write_m(reg_write_m), .result_src_m(result_src_m),
      .alu_result_m(alu_result_m), .read_data_m(read_data_m),
      .rd_m(rd_m), .pc_plus_4m(pc_plus_4m), .stall_m(stall_m)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic        mw;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [2:0]  f3;
   } ins_t;

   ins_t        m = '0;
   int          beat = 0;
   logic [31:0] hold = '0;

   // Byte-by-byte model: byte i of the access lives at address
   // alu+i, i.e. beat (a+i)/4, lane (a+i)%4.
   always @(negedge clk) begin : model
      int n, a, k;
      bit is_mem, split, done, stl;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rd, e_addr;
      if (mdl_on) begin
         is_mem = m.mw || (m.rs == 2'b01);
         case (m.f3[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            default: n = 4;
         endcase
         a = int'(m.alu[1:0]);
         split = (a + n) > 4;
         done = is_mem && mem_ready && (!split || beat == 1);
         stl = is_mem && !done;
         e_be = '0;
         e_wd = '0;
         e_rd = '0;
         for (int i = 0; i < n; i++) begin
            k = a + i;
            if (k / 4 == beat) begin
               e_be[k % 4] = 1'b1;
               e_wd[8*(k%4) +: 8] = m.wd[8*i +: 8];
            end
            if (split && k / 4 == 0)
               e_rd[8*i +: 8] = hold[8*(k%4) +: 8];
            else
               e_rd[8*i +: 8] = mem_rdata[8*(k%4) +: 8];
         end
         if (!m.f3[2] && n == 1 && e_rd[7]) e_rd |= 32'hFFFFFF00;
         if (!m.f3[2] && n == 2 && e_rd[15]) e_rd |= 32'hFFFF0000;
         e_addr = is_mem ? ({m.alu[31:2], 2'b00} + 32'(4 * beat))
                         : 32'h0;
         chk("m_req", mem_req, is_mem);
         chk("m_we", mem_we, m.mw);
         chk("m_addr", mem_addr, e_addr);
         chk("m_be", mem_be, is_mem ? e_be : 4'h0);
         chk("m_wdata", mem_wdata, is_mem ? e_wd : 32'h0);
         chk("m_stall", stall_m, stl);
         chk("m_regwr", reg_write_m, m.rw && !stl);
         chk("m_rsrc", result_src_m, m.rs);
         chk("m_alu", alu_result_m, m.alu);
         chk("m_rd", rd_m, m.rd);
         chk("m_pc4", pc_plus_4m, m.pc);
         if (done && m.rs == 2'b01) chk("m_rdata", read_data_m, e_rd);
         if (rst) begin
            m = '0;
            beat = 0;
            hold = '0;
         end else begin
            if (is_mem && mem_ready) begin
               if (beat == 0 && split) begin
                  hold = mem_rdata;
                  beat = 1;
               end else begin
                  beat = 0;
               end
            end
            if (!stl)
               m = '{reg_write_e, result_src_e, mem_write_e,
                     alu_result_e, write_data_e, rd_e,
                     pc_plus_4e, funct3_e};
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input logic rw, input logic [1:0] rs,
                     input logic mw, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [4:0] rd,
                     input logic [31:0] pc, input logic [2:0] f3);
      reg_write_e  = rw;
      result_src_e = rs;
      mem_write_e  = mw;
      alu_result_e = alu;
      write_data_e = wd;
      rd_e         = rd;
      pc_plus_4e   = pc;
      funct3_e     = f3;
   endtask

   task automatic nop();
      ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 3'b000);
   endtask

   initial begin
      rst = 1'b1;
      nop();
      mem_ready = 1'b1;
      mem_rdata = 32'h12345678;
      step();
      step();
      mdl_on = 1'b1;
      @(negedge clk);
      chk("rst_req", mem_req, 0);
      chk("rst_stall", stall_m, 0);
      chk("rst_regwr", reg_write_m, 0);
      chk("rst_rdata", read_data_m, 0);
      step();
      rst = 1'b0;

      ex(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 5'd5, 32'h104, F3_W);
      mem_rdata = 32'hDEADBEEF;
      step();
      nop();
      @(negedge clk);
      chk("lw_be", mem_be, 4'hF);
      chk("lw_addr", mem_addr, 32'h100);
      chk("lw_data", read_data_m, 32'hDEADBEEF);
      chk("lw_stall", stall_m, 0);

      ex(1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 5'd6, 32'h208, F3_B);
      mem_rdata = 32'h80FFFFFF;
      step();
      ex(1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 5'd7, 32'h20C, F3_BU);
      @(negedge clk);
      chk("lb_be", mem_be, 4'b1000);
      chk("lb_data", read_data_m, 32'hFFFFFF80);
      step();
      nop();
      @(negedge clk);
      chk("lbu_data", read_data_m, 32'h00000080);

      ex(1'b0, 2'b00, 1'b1, 32'h302, 32'h1234ABCD, 5'd0, 32'h310, F3_H);
      step();
      nop();
      @(negedge clk);
      chk("sh_addr", mem_addr, 32'h300);
      chk("sh_be", mem_be, 4'b1100);
      chk("sh_wdata", mem_wdata, 32'hABCD0000);
      chk("sh_we", mem_we, 1);

      ex(1'b1, 2'b01, 1'b0, 32'h401, 32'h0, 5'd9, 32'h410, F3_W);
      mem_rdata = 32'h44332211;
      step();
      nop();
      @(negedge clk);
      chk("mis0_addr", mem_addr, 32'h400);
      chk("mis0_be", mem_be, 4'b1110);
      chk("mis0_stall", stall_m, 1);
      chk("mis0_regwr", reg_write_m, 0);
      step();
      mem_rdata = 32'h88776655;
      @(negedge clk);
      chk("mis1_addr", mem_addr, 32'h404);
      chk("mis1_be", mem_be, 4'b0001);
      chk("mis1_stall", stall_m, 0);
      chk("mis1_regwr", reg_write_m, 1);
      chk("mis1_data", read_data_m, 32'h55443322);
      step();

      ex(1'b0, 2'b00, 1'b1, 32'h500, 32'hCAFEF00D, 5'd0, 32'h510, F3_W);
      mem_ready = 1'b0;
      step();
      ex(1'b1, 2'b00, 1'b0, 32'h999, 32'h5555, 5'd3, 32'h99C, F3_W);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("sw_stall", stall_m, 1);
         chk("sw_addr", mem_addr, 32'h500);
         chk("sw_be", mem_be, 4'hF);
         chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
         chk("sw_hold", alu_result_m, 32'h500);
         step();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("sw_done", stall_m, 0);
      step();
      nop();

      ex(1'b0, 2'b00, 1'b1, 32'hFFFFFFFE, 32'hAABBCCDD, 5'd0, 32'h0, F3_W);
      step();
      nop();
      @(negedge clk);
      chk("wr0_addr", mem_addr, 32'hFFFFFFFC);
      chk("wr0_be", mem_be, 4'b1100);
      chk("wr0_stall", stall_m, 1);
      step();
      mem_ready = 1'b0;
      @(negedge clk);
      chk("wr1_addr", mem_addr, 32'h0);
      chk("wr1_req", mem_req, 1);
      step();
      rst = 1'b1;
      @(negedge clk);
      step();
      rst = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("mrst_req", mem_req, 0);
      chk("mrst_stall", stall_m, 0);
      chk("mrst_be", mem_be, 0);
      chk("mrst_addr", mem_addr, 0);
      chk("mrst_wdata", mem_wdata, 0);
      chk("mrst_alu", alu_result_m, 0);

      ex(1'b0, 2'b00, 1'b1, 32'hFFFFFFFE, 32'hAABBCCDD, 5'd0, 32'h0, F3_W);
      step();
      nop();
      @(negedge clk);
      step();
      @(negedge clk);
      chk("wrap_addr", mem_addr, 32'h0);
      chk("wrap_req", mem_req, 1);
      chk("wrap_stall", stall_m, 0);
      step();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
